// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: snapshots runnable descriptors on go, issues them lowest index first,
// and waits for each completion. Optional cycle counter under DMA_SCHED_PERF_EN.
module dma_desc_sched #(
    parameter int NUM_DESC = 2,
    parameter int IDX_W    = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go_i,
    input  logic                abort_i,
    input  logic [NUM_DESC-1:0] desc_en_i,
    input  logic [NUM_DESC-1:0] desc_zero_i,
    output logic                desc_valid_o,
    output logic [IDX_W-1:0]    desc_sel_o,
    input  logic                desc_ready_i,
    input  logic                desc_done_i,
    input  logic                desc_err_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [IDX_W-1:0]    err_idx_o
`ifdef DMA_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_cycles_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [NUM_DESC-1:0]   pending_r;
    logic [NUM_DESC-1:0]   pending_nxt_s;
    logic [NUM_DESC-1:0]   snap_s;
    logic [NUM_DESC-1:0]   sel_mask_s;
    logic [IDX_W-1:0]      sel_r;
    logic [IDX_W-1:0]      sel_nxt_s;
    logic [IDX_W-1:0]      err_idx_r;
    logic [IDX_W-1:0]      err_idx_nxt_s;
    logic                  error_r;
    logic                  error_nxt_s;
    logic                  abort_r;
    logic                  abort_nxt_s;
    logic                  go_q_r;
    logic                  start_s;
    logic                  desc_valid_r;
    logic                  busy_r;
    logic                  done_r;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_DESC-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_DESC - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign start_s    = go_i & ~go_q_r & (state_r == ST_IDLE);
    assign snap_s     = desc_en_i & ~desc_zero_i;
    assign sel_mask_s = NUM_DESC'(1'b1) << sel_r;

    // Next-state and next-datapath decode for the run sequencer
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        sel_nxt_s     = sel_r;
        error_nxt_s   = error_r;
        err_idx_nxt_s = err_idx_r;
        abort_nxt_s   = abort_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    pending_nxt_s = snap_s;
                    error_nxt_s   = 1'b0;
                    err_idx_nxt_s = '0;
                    if (snap_s == '0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SCAN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                sel_nxt_s   = lowest_idx(pending_r);
                state_nxt_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A handshake takes priority over a same-cycle abort; the abort is remembered
                if (desc_ready_i) begin
                    abort_nxt_s = abort_r | abort_i;
                    state_nxt_s = ST_WAIT;
                end else if (abort_i) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                abort_nxt_s = abort_r | abort_i;
                if (desc_done_i) begin
                    pending_nxt_s = pending_r & ~sel_mask_s;
                    if (desc_err_i && !error_r) begin
                        error_nxt_s   = 1'b1;
                        err_idx_nxt_s = sel_r;
                    end else begin
                        error_nxt_s   = error_r;
                    end
                    if (abort_r || abort_i || desc_err_i || (pending_nxt_s == '0)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SCAN;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                abort_nxt_s = 1'b0;
                if (!go_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                pending_nxt_s = '0;
                abort_nxt_s   = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r    <= '0;
            sel_r        <= '0;
            error_r      <= 1'b0;
            err_idx_r    <= '0;
            abort_r      <= 1'b0;
            go_q_r       <= 1'b0;
            desc_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            pending_r    <= pending_nxt_s;
            sel_r        <= sel_nxt_s;
            error_r      <= error_nxt_s;
            err_idx_r    <= err_idx_nxt_s;
            abort_r      <= abort_nxt_s;
            go_q_r       <= go_i;
            desc_valid_r <= (state_nxt_s == ST_ISSUE);
            busy_r       <= (state_nxt_s == ST_SCAN) || (state_nxt_s == ST_ISSUE) ||
                            (state_nxt_s == ST_WAIT);
            done_r       <= (state_nxt_s == ST_DONE);
        end
    end

    assign desc_valid_o = desc_valid_r;
    assign desc_sel_o   = sel_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign error_o      = error_r;
    assign err_idx_o    = err_idx_r;

`ifdef DMA_SCHED_PERF_EN
    logic [31:0] perf_r;

    // Saturating count of busy cycles for the current run
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_r <= 32'd0;
        end else if (start_s) begin
            perf_r <= 32'd0;
        end else if (busy_r && (perf_r != 32'hFFFF_FFFF)) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_cycles_o = perf_r;
`endif

endmodule

// File: tb/tb_dma_desc_sched.sv
// Randomized self-checking bench for dma_desc_sched (4 slots) against an issue-order reference model.
module tb_dma_desc_sched;

    localparam int NUM_DESC = 4;
    localparam int IDX_W    = 2;

    logic                clk;
    logic                rst;
    logic                go_i;
    logic                abort_i;
    logic [NUM_DESC-1:0] desc_en_i;
    logic [NUM_DESC-1:0] desc_zero_i;
    logic                desc_valid_o;
    logic [IDX_W-1:0]    desc_sel_o;
    logic                desc_ready_i;
    logic                desc_done_i;
    logic                desc_err_i;
    logic                busy_o;
    logic                done_o;
    logic                error_o;
    logic [IDX_W-1:0]    err_idx_o;
`ifdef DMA_SCHED_PERF_EN
    logic [31:0]         perf_cycles_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int got_q[$];

    dma_desc_sched #(.NUM_DESC(NUM_DESC), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .go_i         (go_i),
        .abort_i      (abort_i),
        .desc_en_i    (desc_en_i),
        .desc_zero_i  (desc_zero_i),
        .desc_valid_o (desc_valid_o),
        .desc_sel_o   (desc_sel_o),
        .desc_ready_i (desc_ready_i),
        .desc_done_i  (desc_done_i),
        .desc_err_i   (desc_err_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .err_idx_o    (err_idx_o)
`ifdef DMA_SCHED_PERF_EN
        ,
        .perf_cycles_o(perf_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!desc_valid_o && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_valid_seen"}, 32'(desc_valid_o), 32'd1);
    endtask

    task automatic finish_run();
        go_i         = 1'b0;
        abort_i      = 1'b0;
        desc_ready_i = 1'b0;
        desc_done_i  = 1'b0;
        desc_err_i   = 1'b0;
        step();
        step();
    endtask

    // One full run with a randomized streamer, checked against the issue-order model
    task automatic run_one(input logic [3:0] en, input logic [3:0] zero, input logic [3:0] errm,
                           input bit bp);
        int   c, first_valid, cnt, cur;
        bit   busy_seen, fin, real_done, exp_err;
        int   exp_idx;
        exp_q.delete();
        got_q.delete();
        exp_err = 1'b0;
        exp_idx = 0;
        for (int i = 0; i < NUM_DESC; i++) begin
            if (en[i] && !zero[i] && !exp_err) begin
                exp_q.push_back(i);
                if (errm[i]) begin
                    exp_err = 1'b1;
                    exp_idx = i;
                end
            end
        end
        desc_en_i   = en;
        desc_zero_i = zero;
        go_i        = 1'b1;
        c = 0; first_valid = -1; cnt = 0; cur = 0; busy_seen = 1'b0; fin = 1'b0;
        while (!fin && c < 400) begin
            step();
            c++;
            desc_done_i = 1'b0;
            desc_err_i  = 1'b0;
            real_done   = 1'b0;
            desc_en_i   = 4'($urandom);
            desc_zero_i = 4'($urandom);
            if (c == 1) check_eq("start_clears_error", 32'(error_o), 32'd0);
            if (busy_o) busy_seen = 1'b1;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    desc_done_i = 1'b1;
                    desc_err_i  = errm[cur];
                    real_done   = 1'b1;
                end
            end
            if (desc_valid_o) begin
                if (first_valid < 0) first_valid = c;
                desc_ready_i = bp ? 1'($urandom) : 1'b1;
                if (desc_ready_i) begin
                    cur = int'(desc_sel_o);
                    got_q.push_back(cur);
                    cnt = $urandom_range(1, 6);
                end
            end else begin
                desc_ready_i = 1'($urandom);
                if (!real_done && cnt == 0 && $urandom_range(0, 3) == 0) begin
                    desc_done_i = 1'b1;
                    desc_err_i  = 1'($urandom);
                end
            end
            if (done_o) fin = 1'b1;
        end
        desc_done_i = 1'b0;
        desc_err_i  = 1'b0;
        check_eq("run_completes", 32'(fin), 32'd1);
        check_eq("issue_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq("issue_order", 32'(got_q[i]), 32'(exp_q[i]));
        check_eq("error", 32'(error_o), 32'(exp_err));
        if (exp_err) check_eq("err_idx", 32'(err_idx_o), 32'(exp_idx));
        if (exp_q.size() > 0) check_eq("issue_latency", 32'(first_valid), 32'd2);
        else begin
            check_eq("empty_never_busy", 32'(busy_seen), 32'd0);
            check_eq("empty_done_by_n2", 32'(c <= 2), 32'd1);
        end
        check_eq("busy_low_in_done", 32'(busy_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("go_held_done", 32'(done_o), 32'd1);
            check_eq("go_held_no_issue", 32'(desc_valid_o), 32'd0);
        end
        go_i = 1'b0;
        step();
        check_eq("done_clears_in_idle", 32'(done_o), 32'd0);
        check_eq("error_persists", 32'(error_o), 32'(exp_err));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; go_i = 1'b0; abort_i = 1'b0; desc_en_i = 4'd0; desc_zero_i = 4'd0;
        desc_ready_i = 1'b0; desc_done_i = 1'b0; desc_err_i = 1'b0;
        step();
        step();
        check_eq("rst_valid", 32'(desc_valid_o), 32'd0);
        check_eq("rst_sel", 32'(desc_sel_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_error", 32'(error_o), 32'd0);
        check_eq("rst_err_idx", 32'(err_idx_o), 32'd0);
        rst = 1'b0;
        step();

        // Directed: basic, skip, all-zero, error then clearing run
        run_one(4'b0011, 4'b0000, 4'b0000, 1'b0);
        run_one(4'b0010, 4'b0000, 4'b0000, 1'b0);
        run_one(4'b0011, 4'b0011, 4'b0000, 1'b0);
        run_one(4'b0011, 4'b0000, 4'b0001, 1'b0);
        run_one(4'b1111, 4'b0000, 4'b0100, 1'b1);

        // Backpressure: four stalled cycles then a single handshake
        desc_en_i = 4'b0010; desc_zero_i = 4'b0000; desc_ready_i = 1'b0; go_i = 1'b1;
        wait_valid("bp");
        for (int k = 0; k < 4; k++) begin
            check_eq("bp_valid_hold", 32'(desc_valid_o), 32'd1);
            check_eq("bp_sel_hold", 32'(desc_sel_o), 32'd1);
            step();
        end
        desc_ready_i = 1'b1;
        step();
        desc_ready_i = 1'b1;
        check_eq("bp_valid_after_hs", 32'(desc_valid_o), 32'd0);
        step();
        check_eq("bp_single_handshake", 32'(desc_valid_o), 32'd0);
        desc_done_i = 1'b1;
        step();
        desc_done_i = 1'b0;
        check_eq("bp_done", 32'(done_o), 32'd1);
        finish_run();

        // Abort while stalled in ISSUE: descriptor is dropped
        desc_en_i = 4'b0011; desc_ready_i = 1'b0; go_i = 1'b1;
        wait_valid("abort_issue");
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_eq("abort_issue_valid_drop", 32'(desc_valid_o), 32'd0);
        check_eq("abort_issue_done", 32'(done_o), 32'd1);
        finish_run();

        // Abort in WAIT: in-flight descriptor drains, nothing further issued
        desc_en_i = 4'b0011; desc_ready_i = 1'b1; go_i = 1'b1;
        wait_valid("abort_wait");
        check_eq("abort_wait_sel", 32'(desc_sel_o), 32'd0);
        step();
        desc_ready_i = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_eq("abort_wait_still_busy", 32'(busy_o), 32'd1);
        step();
        desc_done_i = 1'b1;
        step();
        desc_done_i = 1'b0;
        check_eq("abort_wait_done", 32'(done_o), 32'd1);
        check_eq("abort_wait_no_issue", 32'(desc_valid_o), 32'd0);
        finish_run();

        // Abort coincident with handshake: handshake wins, run ends after its completion
        desc_en_i = 4'b0011; desc_ready_i = 1'b1; go_i = 1'b1;
        wait_valid("abort_hs");
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        desc_ready_i = 1'b0;
        check_eq("abort_hs_in_wait", 32'(busy_o & ~desc_valid_o), 32'd1);
        step();
        desc_done_i = 1'b1;
        step();
        desc_done_i = 1'b0;
        check_eq("abort_hs_done", 32'(done_o), 32'd1);
        finish_run();

        // Synchronous reset mid-WAIT
        desc_en_i = 4'b0001; desc_ready_i = 1'b1; go_i = 1'b1;
        wait_valid("rst_wait");
        step();
        desc_ready_i = 1'b0;
        rst = 1'b1;
        step();
        check_eq("rst_wait_outputs",
                 32'({desc_valid_o, desc_sel_o, busy_o, done_o, error_o, err_idx_o}), 32'd0);
        rst = 1'b0;
        finish_run();

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            run_one(4'($urandom), 4'($urandom & $urandom), 4'($urandom & $urandom & $urandom),
                    1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
